udp_tx_hdr_insert: RTL and testbench

UDP_TX_HDR_INSERT -- requirements
Module: udp_tx_hdr_insert

---
 rtl/udp_tx_hdr_insert.sv | 178 +++++++++++++++++
 tb/tb_udp_tx_hdr_insert.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_hdr_insert.sv
// UDP transmit header insertion: prepends the 8-byte UDP header to a payload
// stream and hands addresses, length and timestamp to the IP stage.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_hdr_*              header info (addresses, UDP header, timestamp)
//   in_data_*             payload stream, byte 0 at the MSB
//   out_meta_*            registered metadata towards the IP stage
//   out_data_*            UDP segment stream (header followed by payload)
module udp_tx_hdr_insert #(
  parameter int DATA_W = 256,
  parameter int PAD_W  = 5,
  parameter int TS_W   = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              in_hdr_val,
  input  logic [31:0]       in_src_ip,
  input  logic [31:0]       in_dst_ip,
  input  logic [63:0]       in_udp_hdr,
  input  logic [TS_W-1:0]   in_timestamp,
  output logic              in_hdr_rdy,

  input  logic              in_data_val,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_data_last,
  input  logic [PAD_W-1:0]  in_data_padbytes,
  output logic              in_data_rdy,

  output logic              out_meta_val,
  output logic [31:0]       out_src_ip,
  output logic [31:0]       out_dst_ip,
  output logic [15:0]       out_udp_len,
  output logic [TS_W-1:0]   out_timestamp,
  input  logic              out_meta_rdy,

  output logic              out_data_val,
  output logic [DATA_W-1:0] out_data,
  output logic              out_data_last,
  output logic [PAD_W-1:0]  out_data_padbytes,
  input  logic              out_data_rdy
);

  localparam int NBYTES = DATA_W / 8;

  // Output padding of the extra tail beat before adding the saved input pad.
  localparam logic [PAD_W:0] TAIL_BASE = (PAD_W + 1)'(NBYTES - 8);
  localparam logic [PAD_W:0] HDR_BYTES = (PAD_W + 1)'(8);

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    BODY,
    TAIL,
    WAIT_META
  } state_t;

  state_t             state_q;
  logic               meta_pend_q;
  logic [31:0]        src_q;
  logic [31:0]        dst_q;
  logic [63:0]        udp_q;
  logic [TS_W-1:0]    ts_q;
  logic [63:0]        carry_q;
  logic [PAD_W-1:0]   pad_q;

  logic               data_hs;
  logic [PAD_W:0]     pad_ext;
  logic               pad_big;
  logic [PAD_W:0]     pad_sub;
  logic [PAD_W:0]     tail_pad;
  logic [63:0]        lead_d;

  assign out_meta_val  = meta_pend_q;
  assign out_src_ip    = src_q;
  assign out_dst_ip    = dst_q;
  assign out_udp_len   = udp_q[31:16];
  assign out_timestamp = ts_q;

  assign data_hs  = in_data_val && in_data_rdy;
  assign pad_ext  = {1'b0, in_data_padbytes};
  // The 8 header bytes shift the stream; a last beat with at least 8 pad
  // bytes absorbs the shifted-out bytes, otherwise a tail beat is needed.
  assign pad_big  = pad_ext >= HDR_BYTES;
  assign pad_sub  = pad_ext - HDR_BYTES;
  assign tail_pad = TAIL_BASE + {1'b0, pad_q};
  assign lead_d   = (state_q == FIRST) ? udp_q : carry_q;

  always_comb begin
    in_hdr_rdy        = 1'b0;
    in_data_rdy       = 1'b0;
    out_data_val      = 1'b0;
    out_data          = '0;
    out_data_last     = 1'b0;
    out_data_padbytes = '0;
    unique case (state_q)
      IDLE: begin
        // State is forced to IDLE by reset, so gate the ready explicitly.
        in_hdr_rdy = !rst;
      end
      FIRST, BODY: begin
        in_data_rdy  = out_data_rdy;
        out_data_val = in_data_val;
        out_data     = {lead_d, in_data[DATA_W-1:64]};
        if (in_data_last && pad_big) begin
          out_data_last     = 1'b1;
          out_data_padbytes = pad_sub[PAD_W-1:0];
        end
      end
      TAIL: begin
        out_data_val      = 1'b1;
        out_data          = {carry_q, {(DATA_W-64){1'b0}}};
        out_data_last     = 1'b1;
        out_data_padbytes = tail_pad[PAD_W-1:0];
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      meta_pend_q <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      udp_q       <= '0;
      ts_q        <= '0;
      carry_q     <= '0;
      pad_q       <= '0;
    end else begin
      // Metadata drains independently of the payload.
      if (meta_pend_q && out_meta_rdy) begin
        meta_pend_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (in_hdr_val) begin
            src_q       <= in_src_ip;
            dst_q       <= in_dst_ip;
            udp_q       <= in_udp_hdr;
            ts_q        <= in_timestamp;
            meta_pend_q <= 1'b1;
            state_q     <= FIRST;
          end
        end
        FIRST, BODY: begin
          if (data_hs) begin
            carry_q <= in_data[63:0];
            if (!in_data_last) begin
              state_q <= BODY;
            end else if (pad_big) begin
              state_q <= WAIT_META;
            end else begin
              pad_q   <= in_data_padbytes;
              state_q <= TAIL;
            end
          end
        end
        TAIL: begin
          if (out_data_rdy) begin
            state_q <= WAIT_META;
          end
        end
        WAIT_META: begin
          if (!meta_pend_q || out_meta_rdy) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_hdr_insert.sv
// Self-checking bench for udp_tx_hdr_insert: scoreboard of expected output
// beats and metadata, directed length cases, random stalls and reset.
module tb_udp_tx_hdr_insert;

  localparam int DW = 256;
  localparam int PW = 5;
  localparam int TW = 64;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_hdr_val;
  logic [31:0]   in_src_ip;
  logic [31:0]   in_dst_ip;
  logic [63:0]   in_udp_hdr;
  logic [TW-1:0] in_timestamp;
  logic          in_hdr_rdy;
  logic          in_data_val;
  logic [DW-1:0] in_data;
  logic          in_data_last;
  logic [PW-1:0] in_data_padbytes;
  logic          in_data_rdy;
  logic          out_meta_val;
  logic [31:0]   out_src_ip;
  logic [31:0]   out_dst_ip;
  logic [15:0]   out_udp_len;
  logic [TW-1:0] out_timestamp;
  logic          out_meta_rdy;
  logic          out_data_val;
  logic [DW-1:0] out_data;
  logic          out_data_last;
  logic [PW-1:0] out_data_padbytes;
  logic          out_data_rdy;

  always #5 clk = ~clk;

  udp_tx_hdr_insert #(.DATA_W(DW), .PAD_W(PW), .TS_W(TW)) dut (
    .clk(clk),
    .rst(rst),
    .in_hdr_val(in_hdr_val),
    .in_src_ip(in_src_ip),
    .in_dst_ip(in_dst_ip),
    .in_udp_hdr(in_udp_hdr),
    .in_timestamp(in_timestamp),
    .in_hdr_rdy(in_hdr_rdy),
    .in_data_val(in_data_val),
    .in_data(in_data),
    .in_data_last(in_data_last),
    .in_data_padbytes(in_data_padbytes),
    .in_data_rdy(in_data_rdy),
    .out_meta_val(out_meta_val),
    .out_src_ip(out_src_ip),
    .out_dst_ip(out_dst_ip),
    .out_udp_len(out_udp_len),
    .out_timestamp(out_timestamp),
    .out_meta_rdy(out_meta_rdy),
    .out_data_val(out_data_val),
    .out_data(out_data),
    .out_data_last(out_data_last),
    .out_data_padbytes(out_data_padbytes),
    .out_data_rdy(out_data_rdy)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
    logic [PW-1:0] pad;
    bit            tail;
  } obeat_t;

  typedef struct {
    logic [31:0]   s;
    logic [31:0]   t;
    logic [15:0]   len;
    logic [TW-1:0] ts;
  } meta_t;

  obeat_t exp_q[$];
  meta_t  exp_meta[$];

  int checks = 0;
  int errors = 0;
  int stall = 0;
  int hdr_cnt = 0;
  int last_cnt = 0;
  int meta_cnt = 0;
  int beats_obs = 0;
  int tail_seen = 0;
  logic [PW-1:0] last_pad_obs;
  logic [7:0]    byte0_obs;
  logic [7:0]    pl24;
  logic [63:0]   first_obs;
  logic [63:0]   last_udp;

  task automatic sb_monitor();
    obeat_t e;
    meta_t m;
    logic [DW-1:0] hd;
    logic hl;
    logic [PW-1:0] hp;
    bit hold;
    hold = 0;
    forever begin
      @(posedge clk);
      #1;
      out_data_rdy = ($urandom_range(0, 99) >= stall);
      out_meta_rdy = ($urandom_range(0, 99) >= stall);
      @(negedge clk);
      if (rst) begin
        hold = 0;
        continue;
      end
      if (hold) begin
        checks++;
        if (!out_data_val || out_data !== hd ||
            out_data_last !== hl || out_data_padbytes !== hp) begin
          errors++;
          $display("FAIL hold: val=%0b data=%h want val=1 data=%h",
                   out_data_val, out_data, hd);
        end
      end
      hold = out_data_val && !out_data_rdy;
      hd = out_data;
      hl = out_data_last;
      hp = out_data_padbytes;
      if (out_data_val && out_data_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_extra: got %h want no beat", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_data_last !== e.last ||
              (e.last && out_data_padbytes !== e.pad)) begin
            errors++;
            $display("FAIL beat: got %h last=%0b pad=%0d want %h last=%0b pad=%0d",
                     out_data, out_data_last, out_data_padbytes,
                     e.d, e.last, e.pad);
          end
          if (e.tail) begin
            checks++;
            tail_seen++;
            if (in_data_rdy !== 1'b0) begin
              errors++;
              $display("FAIL tail_rdy: in_data_rdy=%0b want 0", in_data_rdy);
            end
          end
        end
        if (beats_obs == 0) first_obs = out_data[DW-1 -: 64];
        byte0_obs = out_data[DW-1 -: 8];
        beats_obs++;
        if (out_data_last) begin
          last_pad_obs = out_data_padbytes;
          last_cnt++;
        end
      end
      if (out_meta_val && out_meta_rdy) begin
        checks++;
        meta_cnt++;
        if (exp_meta.size() == 0) begin
          errors++;
          $display("FAIL meta_extra: got src=%h want no meta", out_src_ip);
        end else begin
          m = exp_meta.pop_front();
          if (out_src_ip !== m.s || out_dst_ip !== m.t ||
              out_udp_len !== m.len || out_timestamp !== m.ts) begin
            errors++;
            $display("FAIL meta: got %h %h %h %h want %h %h %h %h",
                     out_src_ip, out_dst_ip, out_udp_len, out_timestamp,
                     m.s, m.t, m.len, m.ts);
          end
        end
      end
      if (in_hdr_val && in_hdr_rdy) begin
        checks++;
        if (last_cnt != hdr_cnt || meta_cnt != hdr_cnt) begin
          errors++;
          $display("FAIL hdr_early: last=%0d meta=%0d want both %0d",
                   last_cnt, meta_cnt, hdr_cnt);
        end
        hdr_cnt++;
      end
    end
  endtask

  task automatic send_pkt(input int len, input int stop_after);
    logic [7:0] pl[$];
    logic [63:0] udp;
    logic [DW-1:0] w;
    obeat_t e;
    meta_t m;
    int nin, nout, tot, n;
    pl = {};
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
    udp = {16'($urandom), 16'($urandom), 16'(len + 8), 16'($urandom)};
    last_udp = udp;
    if (len > 24) pl24 = pl[24];
    tot = len + 8;
    nin = (len + NB - 1) / NB;
    nout = (tot + NB - 1) / NB;
    for (int b = 0; b < nout; b++) begin
      w = '0;
      for (int i = 0; i < NB; i++) begin
        int k;
        k = b * NB + i;
        if (k < 8) w[DW-1-8*i -: 8] = udp[63-8*k -: 8];
        else if (k < tot) w[DW-1-8*i -: 8] = pl[k-8];
      end
      e.d = w;
      e.last = (b == nout - 1);
      e.pad = PW'(nout * NB - tot);
      e.tail = e.last && (nout > nin);
      exp_q.push_back(e);
    end
    m.s = $urandom;
    m.t = $urandom;
    m.len = udp[31:16];
    m.ts = {$urandom, $urandom};
    exp_meta.push_back(m);

    in_src_ip = m.s;
    in_dst_ip = m.t;
    in_udp_hdr = udp;
    in_timestamp = m.ts;
    in_hdr_val = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_hdr_rdy && n < 5000);
    checks++;
    if (!in_hdr_rdy) begin
      errors++;
      $display("FAIL hdr_timeout: rdy=%0b want 1", in_hdr_rdy);
      in_hdr_val = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_hdr_val = 1'b0;

    for (int b = 0; b < nin; b++) begin
      w = '0;
      for (int i = 0; i < NB; i++) begin
        int k;
        k = b * NB + i;
        if (k < len) w[DW-1-8*i -: 8] = pl[k];
      end
      in_data = w;
      in_data_last = (b == nin - 1);
      in_data_padbytes = PW'(nin * NB - len);
      in_data_val = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!in_data_rdy && n < 5000);
      checks++;
      if (!in_data_rdy) begin
        errors++;
        $display("FAIL data_timeout: rdy=%0b want 1", in_data_rdy);
        in_data_val = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      in_data_val = 1'b0;
      if (stop_after == b + 1) return;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_meta.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || exp_meta.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: beats left %0d meta left %0d want 0 0",
               name, exp_q.size(), exp_meta.size());
      exp_q.delete();
      exp_meta.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_meta_val !== 0 || out_data_val !== 0 ||
        in_hdr_rdy !== 0 || in_data_rdy !== 0) begin
      errors++;
      $display("FAIL reset_valids: mv=%0b dv=%0b hr=%0b dr=%0b want 0 0 0 0",
               out_meta_val, out_data_val, in_hdr_rdy, in_data_rdy);
    end
    checks++;
    if (out_src_ip !== 0 || out_dst_ip !== 0 ||
        out_udp_len !== 0 || out_timestamp !== 0) begin
      errors++;
      $display("FAIL reset_meta: %h %h %h %h want all 0",
               out_src_ip, out_dst_ip, out_udp_len, out_timestamp);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_hdr_rdy !== 1'b1 || in_data_rdy !== 1'b0) begin
      errors++;
      $display("FAIL idle_rdy: hr=%0b dr=%0b want 1 0", in_hdr_rdy, in_data_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_len10();
    beats_obs = 0;
    tail_seen = 0;
    send_pkt(10, -1);
    wait_drain("len10");
    checks++;
    if (beats_obs != 1 || last_pad_obs !== 5'd14) begin
      errors++;
      $display("FAIL len10: beats=%0d pad=%0d want 1 14", beats_obs, last_pad_obs);
    end
    checks++;
    if (first_obs !== last_udp) begin
      errors++;
      $display("FAIL len10_hdr: got %h want %h", first_obs, last_udp);
    end
  endtask

  task automatic test_len24();
    beats_obs = 0;
    send_pkt(24, -1);
    wait_drain("len24");
    checks++;
    if (beats_obs != 1 || last_pad_obs !== 5'd0) begin
      errors++;
      $display("FAIL len24: beats=%0d pad=%0d want 1 0", beats_obs, last_pad_obs);
    end
  endtask

  task automatic test_len25();
    beats_obs = 0;
    tail_seen = 0;
    send_pkt(25, -1);
    wait_drain("len25");
    checks++;
    if (beats_obs != 2 || last_pad_obs !== 5'd31 || tail_seen != 1) begin
      errors++;
      $display("FAIL len25: beats=%0d pad=%0d tail=%0d want 2 31 1",
               beats_obs, last_pad_obs, tail_seen);
    end
    checks++;
    if (byte0_obs !== pl24) begin
      errors++;
      $display("FAIL len25_byte0: got %h want %h", byte0_obs, pl24);
    end
  endtask

  task automatic test_len64();
    beats_obs = 0;
    tail_seen = 0;
    send_pkt(64, -1);
    wait_drain("len64");
    checks++;
    if (beats_obs != 3 || last_pad_obs !== 5'd24 || tail_seen != 1) begin
      errors++;
      $display("FAIL len64: beats=%0d pad=%0d tail=%0d want 3 24 1",
               beats_obs, last_pad_obs, tail_seen);
    end
  endtask

  task automatic test_random_stall();
    int l0, m0;
    l0 = last_cnt;
    m0 = meta_cnt;
    stall = 40;
    for (int p = 0; p < 100; p++) send_pkt($urandom_range(1, 100), -1);
    wait_drain("random");
    stall = 0;
    checks++;
    if (last_cnt - l0 != 100 || meta_cnt - m0 != 100) begin
      errors++;
      $display("FAIL random_count: last=%0d meta=%0d want 100 100",
               last_cnt - l0, meta_cnt - m0);
    end
  endtask

  task automatic test_reset_mid();
    stall = 0;
    send_pkt(100, 2);
    rst = 1'b1;
    #1;
    checks++;
    if (out_data_val !== 0 || out_meta_val !== 0 ||
        in_hdr_rdy !== 0 || in_data_rdy !== 0) begin
      errors++;
      $display("FAIL rst_mid: dv=%0b mv=%0b hr=%0b dr=%0b want 0 0 0 0",
               out_data_val, out_meta_val, in_hdr_rdy, in_data_rdy);
    end
    exp_q.delete();
    exp_meta.delete();
    hdr_cnt = 0;
    last_cnt = 0;
    meta_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    beats_obs = 0;
    send_pkt(40, -1);
    wait_drain("after_rst");
    checks++;
    if (beats_obs != 2 || last_pad_obs !== 5'd16) begin
      errors++;
      $display("FAIL after_rst: beats=%0d pad=%0d want 2 16",
               beats_obs, last_pad_obs);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_hdr_val = 1'b0;
    in_src_ip = '0;
    in_dst_ip = '0;
    in_udp_hdr = '0;
    in_timestamp = '0;
    in_data_val = 1'b0;
    in_data = '0;
    in_data_last = 1'b0;
    in_data_padbytes = '0;
    out_meta_rdy = 1'b0;
    out_data_rdy = 1'b0;
    fork
      sb_monitor();
    join_none
    test_reset();
    test_len10();
    test_len24();
    test_len25();
    test_len64();
    test_random_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
